pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Power-up/recovery sequencer for the video pixel-clock PLL (50 MHz ref -> 148.5 MHz pixel clock).
//  Drives the PLL's active-high reset, synchronises and debounces its lock output, retries failed
//  lock attempts, and releases a system reset for the pixel domain only after lock is stable.
//  Runs on the 50 MHz reference clock; pixel-domain reset re-synchronisation is done by the consumer.
// PARAMETERS
//  RST_HOLD_CYC     64     cycles pll_areset held high per reset attempt (>=2)
//  LOCK_TIMEOUT_CYC 50000  cycles in WAIT_LOCK before an attempt is declared failed (1 ms @ 50 MHz)
//  STABLE_CYC       1024   consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRY        3      failed attempts before entering FAULT (>=1)
//  CW               16     width of internal timers; must hold max(all *_CYC) - 1
// PORTS
//  clk          in   1  50 MHz reference clock, same as PLL inclk0
//  reset_n      in   1  synchronous active-low reset
//  pll_locked   in   1  PLL locked, asynchronous to clk
//  restart      in   1  single-cycle request to re-run the full sequence
//  pll_areset   out  1  to PLL areset, active high
//  sys_rst_n    out  1  active-low reset for pixel-clock logic
//  pll_ready    out  1  high while in RUN
//  fault        out  1  high while in FAULT
//  seq_state    out  3  current state encoding (debug)
//  loss_count   out  8  lock-loss events in RUN, saturating (only with PLL_SEQ_LOSS_CNT_EN)
// BEHAVIOUR
//  - All outputs registered; decoded from next-state, so they change on the edge the state changes.
//  - Reset (reset_n=0 at edge): state=HOLD, pll_areset=1, sys_rst_n=0, pll_ready=0, fault=0,
//    seq_state=0, retry_cnt=0, timers=0, loss_count=0.
//  - pll_locked -> 2-flop synchroniser -> lock_s (2-cycle latency); only lock_s used below.
//  - States (seq_state): HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
//  - HOLD: pll_areset=1; after RST_HOLD_CYC cycles in HOLD -> WAIT_LOCK (timer cleared).
//  - WAIT_LOCK: pll_areset=0; lock_s=1 -> STABLE (stable timer cleared). Timer reaching
//    LOCK_TIMEOUT_CYC-1 with lock_s=0 -> retry_cnt+1; if new retry_cnt==MAX_RETRY -> FAULT else HOLD.
//  - STABLE: pll_areset=0; lock_s=0 -> WAIT_LOCK (timeout timer restarted, no retry increment);
//    STABLE_CYC consecutive lock_s=1 cycles -> RUN, retry_cnt cleared.
//  - Latency: locked rising at edge L with no glitch -> sys_rst_n=1 at edge L+3+STABLE_CYC.
//  - RUN: sys_rst_n=1, pll_ready=1. lock_s=0 -> HOLD (sys_rst_n=0 on that edge), loss event.
//  - FAULT: pll_areset=1, fault=1, sys_rst_n=0; exits only via restart or reset_n.
//  - restart=1 in any state -> HOLD next edge; retry_cnt and timers cleared. Priority:
//    reset_n > restart > lock/timeout events. restart coincident with RUN lock loss: not a loss event.
//  - sys_rst_n=0 and pll_ready=0 in every state except RUN; fault=1 only in FAULT.
//  - retry_cnt width clog2(MAX_RETRY+1); timers never wrap (compare then clear).
// CONFIGURATION
//  PLL_SEQ_LOSS_CNT_EN defined: loss_count port present; +1 per RUN->HOLD lock-loss transition,
//    saturates at 255, cleared only by reset_n (not restart).
//  Undefined: loss_count port and counter absent; all other behaviour identical.
// TESTING (RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRY=2, macro defined)
//  1 release reset_n, pll_locked rises at cycle 10 and holds -> pll_areset=1 cycles 0-3,
//    seq_state 0->1->2->3, sys_rst_n and pll_ready rise at cycle 21.
//  2 pll_locked held 0 -> two HOLD/WAIT attempts, fault=1 at cycle 48, pll_areset stays 1, sys_rst_n=0.
//  3 1-cycle low glitch on pll_locked 5 cycles into STABLE -> back to WAIT_LOCK, sys_rst_n stays 0,
//    RUN reached 8 cycles after lock_s returns, fault=0.
//  4 in RUN drop pll_locked -> sys_rst_n=0 3 cycles later, pll_areset high 4 cycles, loss_count=1;
//    relock -> RUN again, loss_count stays 1.
//  5 in FAULT pulse restart -> seq_state=0 next edge, retry_cnt=0, fault=0; lock -> RUN.
//  6 reset_n low mid-RUN with restart=1 same cycle -> all outputs at reset values next edge, loss_count=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with retry and fault handling
// Define PLL_SEQ_LOSS_CNT_EN to add the saturating loss_count port.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 1024,
  parameter int MAX_RETRY        = 3,
  parameter int CW               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_areset,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fault,
`ifdef PLL_SEQ_LOSS_CNT_EN
  output logic [7:0] loss_count,
`endif
  output logic [2:0] seq_state
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // pll_locked is asynchronous; only lock_s is used downstream
  logic sync1;
  logic lock_s;

  always_ff @(posedge clk) begin
    sync1  <= pll_locked;
    lock_s <= sync1;
  end

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   timer;
  logic [CW-1:0]   timer_nx;
  logic [RW-1:0]   retry_cnt;
  logic [RW-1:0]   retry_nx;
  logic [RW-1:0]   retry_inc;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic            loss_evt;
`endif

  assign retry_inc = retry_cnt + RW'(1);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    retry_nx = retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
    loss_evt = 1'b0;
`endif
    if (restart) begin
      state_nx = S_HOLD;
      timer_nx = '0;
      retry_nx = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (timer == HOLD_LAST) begin
            state_nx = S_WAIT;
            timer_nx = '0;
          end else begin
            timer_nx = timer + CW'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_nx = S_STABLE;
            timer_nx = '0;
          end else if (timer == TIMEOUT_LAST) begin
            timer_nx = '0;
            retry_nx = retry_inc;
            state_nx = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_HOLD;
          end else begin
            timer_nx = timer + CW'(1);
          end
        end
        S_STABLE: begin
          // a single low lock_s sample restarts the whole lock wait, without a retry
          if (!lock_s) begin
            state_nx = S_WAIT;
            timer_nx = '0;
          end else if (timer == STABLE_LAST) begin
            state_nx = S_RUN;
            timer_nx = '0;
            retry_nx = '0;
          end else begin
            timer_nx = timer + CW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_nx = S_HOLD;
            timer_nx = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
            loss_evt = 1'b1;
`endif
          end
        end
        S_FAULT: begin
          timer_nx = '0;
        end
        default: begin
          state_nx = S_HOLD;
          timer_nx = '0;
          retry_nx = '0;
        end
      endcase
    end
  end

  // outputs decoded from the next state so they move on the same edge as the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_HOLD;
      timer      <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      sys_rst_n  <= 1'b0;
      pll_ready  <= 1'b0;
      fault      <= 1'b0;
      seq_state  <= 3'd0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      retry_cnt  <= retry_nx;
      pll_areset <= (state_nx == S_HOLD) || (state_nx == S_FAULT);
      sys_rst_n  <= (state_nx == S_RUN);
      pll_ready  <= (state_nx == S_RUN);
      fault      <= (state_nx == S_FAULT);
      seq_state  <= state_nx;
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  // survives restart on purpose: only a full reset clears the loss history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loss_count <= 8'd0;
    end else if (loss_evt && (loss_count != 8'hFF)) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
// Timestamp-based reference model plus directed literal checks and random stimulus.
module tb_pll_lock_sequencer;

  localparam int HOLD_N  = 4;
  localparam int TMO_N   = 20;
  localparam int STB_N   = 8;
  localparam int RETRY_N = 2;

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_areset;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [2:0] seq_state;
  logic [7:0] loss_count;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  pll_lock_sequencer #(
    .RST_HOLD_CYC    (HOLD_N),
    .LOCK_TIMEOUT_CYC(TMO_N),
    .STABLE_CYC      (STB_N),
    .MAX_RETRY       (RETRY_N),
    .CW              (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_areset(pll_areset),
    .sys_rst_n (sys_rst_n),
    .pll_ready (pll_ready),
    .fault     (fault),
`ifdef PLL_SEQ_LOSS_CNT_EN
    .loss_count(loss_count),
`endif
    .seq_state (seq_state)
  );

`ifndef PLL_SEQ_LOSS_CNT_EN
  assign loss_count = 8'd0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: phase plus the edge index at which the phase was entered
  int ecnt = 0;
  int rel = -1;
  int m_ph = P_HOLD;
  int m_enter = 0;
  int m_retry = 0;
  int m_loss = 0;
  int m_p1 = 0;
  int m_p2 = 0;
  bit mvalid = 1'b0;

  logic       obs_areset[0:1023];
  logic       obs_srn[0:1023];
  logic       obs_ready[0:1023];
  logic       obs_fault[0:1023];
  logic [2:0] obs_state[0:1023];
  logic [7:0] obs_loss[0:1023];

  task automatic go(input int p);
    m_ph = p;
    m_enter = ecnt + 1;
  endtask

  task automatic model_step();
    int ls;
    int el;
    ls = m_p2;
    m_p2 = m_p1;
    m_p1 = int'(pll_locked);
    ecnt++;
    el = ecnt - m_enter + 1;
    if (!reset_n) begin
      go(P_HOLD);
      m_retry = 0;
      m_loss = 0;
      rel = -1;
      mvalid = 1'b1;
    end else begin
      rel++;
      if (restart) begin
        go(P_HOLD);
        m_retry = 0;
      end else begin
        case (m_ph)
          P_HOLD: if (el == HOLD_N) go(P_WAIT);
          P_WAIT: begin
            if (ls == 1) go(P_STB);
            else if (el == TMO_N) begin
              m_retry++;
              go((m_retry == RETRY_N) ? P_FLT : P_HOLD);
            end
          end
          P_STB: begin
            if (ls == 0) go(P_WAIT);
            else if (el == STB_N) begin
              go(P_RUN);
              m_retry = 0;
            end
          end
          P_RUN: begin
            if (ls == 0) begin
              go(P_HOLD);
              if (m_loss < 255) m_loss++;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (mvalid) begin
        check("pll_areset", 32'(pll_areset), 32'(m_ph == P_HOLD || m_ph == P_FLT));
        check("sys_rst_n", 32'(sys_rst_n), 32'(m_ph == P_RUN));
        check("pll_ready", 32'(pll_ready), 32'(m_ph == P_RUN));
        check("fault", 32'(fault), 32'(m_ph == P_FLT));
        check("seq_state", 32'(seq_state), 32'(m_ph));
`ifdef PLL_SEQ_LOSS_CNT_EN
        check("loss_count", 32'(loss_count), 32'(m_loss));
`endif
        if (rel >= 0 && rel < 1024) begin
          obs_areset[rel] = pll_areset;
          obs_srn[rel]    = sys_rst_n;
          obs_ready[rel]  = pll_ready;
          obs_fault[rel]  = fault;
          obs_state[rel]  = seq_state;
          obs_loss[rel]   = loss_count;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    restart = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  int d;
  int r;
  int seg;
  logic lvl;

  initial begin
    // clean lock: rises during cycle 10, RUN at cycle 21
    pll_locked = 1'b0;
    do_reset();
    step(10);
    pll_locked = 1'b1;
    step(25);
    check("t1_areset_c3", 32'(obs_areset[2]), 32'd1);
    check("t1_areset_c4", 32'(obs_areset[3]), 32'd0);
    check("t1_state_wait", 32'(obs_state[11]), 32'd1);
    check("t1_state_stable", 32'(obs_state[12]), 32'd2);
    check("t1_srn_before", 32'(obs_srn[19]), 32'd0);
    check("t1_srn_rise", 32'(obs_srn[20]), 32'd1);
    check("t1_ready_rise", 32'(obs_ready[20]), 32'd1);

    // lock loss in RUN, then relock
    d = rel;
    pll_locked = 1'b0;
    step(10);
    check("t4_srn_d2", 32'(obs_srn[d+2]), 32'd1);
    check("t4_srn_d3", 32'(obs_srn[d+3]), 32'd0);
    check("t4_areset_d2", 32'(obs_areset[d+2]), 32'd0);
    for (int k = 3; k <= 6; k++) check("t4_areset_hold", 32'(obs_areset[d+k]), 32'd1);
    check("t4_areset_d7", 32'(obs_areset[d+7]), 32'd0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    check("t4_loss_one", 32'(obs_loss[d+3]), 32'd1);
`endif
    pll_locked = 1'b1;
    step(30);
    check("t4_relock_ready", 32'(pll_ready), 32'd1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    check("t4_loss_stays", 32'(loss_count), 32'd1);
`endif

    // one-cycle glitch five cycles into STABLE
    pll_locked = 1'b0;
    do_reset();
    step(10);
    pll_locked = 1'b1;
    step(7);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(20);
    check("t3_state_18", 32'(obs_state[18]), 32'd2);
    check("t3_state_19", 32'(obs_state[19]), 32'd1);
    check("t3_state_20", 32'(obs_state[20]), 32'd2);
    check("t3_srn_27", 32'(obs_srn[27]), 32'd0);
    check("t3_srn_28", 32'(obs_srn[28]), 32'd1);
    check("t3_fault", 32'(obs_fault[19]), 32'd0);

    // never locks: two attempts then FAULT at cycle 48
    pll_locked = 1'b0;
    do_reset();
    step(50);
    check("t2_state_23", 32'(obs_state[23]), 32'd0);
    check("t2_state_27", 32'(obs_state[27]), 32'd1);
    check("t2_fault_46", 32'(obs_fault[46]), 32'd0);
    check("t2_fault_47", 32'(obs_fault[47]), 32'd1);
    check("t2_areset_47", 32'(obs_areset[47]), 32'd1);
    check("t2_srn_47", 32'(obs_srn[47]), 32'd0);
    check("t2_state_47", 32'(obs_state[47]), 32'd4);

    // restart out of FAULT clears the retry count
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    r = rel;
    check("t5_state", 32'(seq_state), 32'd0);
    check("t5_fault", 32'(fault), 32'd0);
    step(30);
    check("t5_retry_cleared", 32'(obs_state[r+24]), 32'd0);
    check("t5_no_fault", 32'(obs_fault[r+24]), 32'd0);
    pll_locked = 1'b1;
    step(30);
    check("t5_run", 32'(pll_ready), 32'd1);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(30);

    // reset_n wins over a simultaneous restart in RUN
    reset_n = 1'b0;
    restart = 1'b1;
    step(1);
    check("t6_areset", 32'(pll_areset), 32'd1);
    check("t6_srn", 32'(sys_rst_n), 32'd0);
    check("t6_ready", 32'(pll_ready), 32'd0);
    check("t6_fault", 32'(fault), 32'd0);
    check("t6_state", 32'(seq_state), 32'd0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    check("t6_loss", 32'(loss_count), 32'd0);
`endif
    reset_n = 1'b1;
    restart = 1'b0;

    // randomized lock segments with sporadic restart and reset
    seg = 0;
    lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lvl = 1'($urandom_range(0, 1));
        seg = int'($urandom_range(1, 60));
      end
      seg--;
      pll_locked = lvl;
      restart = ($urandom_range(0, 79) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    reset_n = 1'b1;
    restart = 1'b0;

    // repeated lock losses drive loss_count into saturation
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    pll_locked = 1'b1;
    step(20);
    for (int i = 0; i < 270; i++) begin
      pll_locked = 1'b0;
      step(2);
      pll_locked = 1'b1;
      step(18);
    end
    check("sat_ready", 32'(pll_ready), 32'd1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    check("sat_loss", 32'(loss_count), 32'd255);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
